// File: rtl/elixirchip_es1_spu_sll_arb_pkg.sv
// Shared types and helpers for the SPU sll arbiter slice.
// Default widths match a 4-requester, 8-bit lane configuration.
package elixirchip_es1_spu_sll_arb_pkg;

  localparam int ARB_NUM_REQ    = 4;
  localparam int ARB_LATENCY    = 2;
  localparam int ARB_DATA_BITS  = 8;
  localparam int ARB_SHIFT_BITS = $clog2(ARB_DATA_BITS) + 1;
  localparam int ARB_TAG_BITS   = 4;
  localparam int ARB_ID_BITS    = $clog2(ARB_NUM_REQ);

  typedef logic [ARB_ID_BITS-1:0]    id_t;
  typedef logic [ARB_TAG_BITS-1:0]   tag_t;
  typedef logic [ARB_DATA_BITS-1:0]  data_t;
  typedef logic [ARB_SHIFT_BITS-1:0] shift_t;

  typedef struct packed {
    logic  valid;
    id_t   id;
    tag_t  tag;
    data_t data;
  } stage_t;

  // Shifts at or beyond the data width flush every bit out.
  function automatic data_t sll_sat(input data_t d, input shift_t s);
    if (s >= shift_t'(ARB_DATA_BITS)) return '0;
    return d << s;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_sll_arbiter_rr.sv
// Generic round-robin arbiter; the pointer moves past each granted
// requester so every eligible lane is served in turn.
module elixirchip_es1_spu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cke,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_BITS-1:0] o_gidx,
  output logic               o_any
);

  logic [ID_BITS-1:0] r_ptr;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_BITS-1:0] w_gidx;
  logic               w_any;

  assign w_elig = i_req & i_mask & {NUM_REQ{cke}};

  // Scan from farthest to nearest so the closest eligible lane wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any  = 1'b1;
        w_gidx = ID_BITS'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    if (w_any) w_grant[w_gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (cke && w_any) begin
      if (w_gidx == ID_BITS'(NUM_REQ - 1)) r_ptr <= '0;
      else                                 r_ptr <= w_gidx + 1'b1;
    end
  end

  assign o_grant = w_grant;
  assign o_gidx  = w_gidx;
  assign o_any   = w_any;

endmodule

// File: rtl/elixirchip_es1_spu_sll_arbiter.sv
// Shares one pipelined shift-left-logical unit among SPU lanes;
// results return in issue order with the owner's index and tag.
module elixirchip_es1_spu_sll_arbiter
  import elixirchip_es1_spu_sll_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int LATENCY    = ARB_LATENCY,
  parameter int DATA_BITS  = ARB_DATA_BITS,
  parameter int SHIFT_BITS = ARB_SHIFT_BITS,
  parameter int TAG_BITS   = ARB_TAG_BITS,
  parameter int ID_BITS    = ARB_ID_BITS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*SHIFT_BITS-1:0] s_shift,
  input  logic [NUM_REQ*DATA_BITS-1:0]  s_data,
  input  logic [NUM_REQ*TAG_BITS-1:0]   s_tag,
  input  logic [NUM_REQ-1:0]            s_mask,
  output logic                          m_valid,
  output logic [ID_BITS-1:0]            m_id,
  output logic [TAG_BITS-1:0]           m_tag,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          busy,
  output logic [31:0]                   issue_count
);

  logic [NUM_REQ-1:0] w_grant;
  id_t                w_gidx;
  logic               w_any;
  shift_t             w_shift;
  data_t              w_data;
  tag_t               w_tag;
  stage_t             r_pipe [LATENCY];
  logic [31:0]        r_count;
  logic               w_busy;

  elixirchip_es1_spu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .i_req   (s_valid),
    .i_mask  (s_mask),
    .o_grant (w_grant),
    .o_gidx  (w_gidx),
    .o_any   (w_any)
  );

  assign w_shift = s_shift[w_gidx*SHIFT_BITS +: SHIFT_BITS];
  assign w_data  = s_data[w_gidx*DATA_BITS +: DATA_BITS];
  assign w_tag   = s_tag[w_gidx*TAG_BITS +: TAG_BITS];

  // Payload only moves with a valid beat, so outputs hold across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < LATENCY; j++) r_pipe[j] <= '0;
      r_count <= '0;
    end else if (cke) begin
      r_pipe[0].valid <= w_any;
      if (w_any) begin
        r_pipe[0].id   <= w_gidx;
        r_pipe[0].tag  <= w_tag;
        r_pipe[0].data <= sll_sat(w_data, w_shift);
        r_count        <= r_count + 32'd1;
      end
      for (int j = 1; j < LATENCY; j++) begin
        r_pipe[j].valid <= r_pipe[j-1].valid;
        if (r_pipe[j-1].valid) begin
          r_pipe[j].id   <= r_pipe[j-1].id;
          r_pipe[j].tag  <= r_pipe[j-1].tag;
          r_pipe[j].data <= r_pipe[j-1].data;
        end
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int j = 0; j < LATENCY; j++) w_busy = w_busy | r_pipe[j].valid;
  end

  assign s_ready     = w_grant;
  assign m_valid     = r_pipe[LATENCY-1].valid;
  assign m_id        = r_pipe[LATENCY-1].id;
  assign m_tag       = r_pipe[LATENCY-1].tag;
  assign m_data      = r_pipe[LATENCY-1].data;
  assign busy        = w_busy;
  assign issue_count = r_count;

endmodule

// File: tb/tb_elixirchip_es1_spu_sll_arbiter.sv
// Directed and model-checked stimulus for the SPU sll arbiter
// (NUM_REQ=4, LATENCY=2, DATA_BITS=8).
module tb_elixirchip_es1_spu_sll_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cke;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [15:0] s_shift;
  logic [31:0] s_data;
  logic [15:0] s_tag;
  logic [3:0]  s_mask;
  logic        m_valid;
  logic [1:0]  m_id;
  logic [3:0]  m_tag;
  logic [7:0]  m_data;
  logic        busy;
  logic [31:0] issue_count;

  int ncmp = 0;
  int nerr = 0;

  elixirchip_es1_spu_sll_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cke         (cke),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_shift     (s_shift),
    .s_data      (s_data),
    .s_tag       (s_tag),
    .s_mask      (s_mask),
    .m_valid     (m_valid),
    .m_id        (m_id),
    .m_tag       (m_tag),
    .m_data      (m_data),
    .busy        (busy),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp;
    for (int i = 0; i < 4; i++) begin
      s_data[i*8 +: 8]  = 8'h01;
      s_shift[i*4 +: 4] = 4'(i);
      s_tag[i*4 +: 4]   = 4'(i);
    end
  endtask

  // Reference model state for the random phase
  int         mptr;
  logic       p0v, mv;
  logic [1:0] p0id, mid;
  logic [3:0] p0tag, mtag;
  logic [7:0] p0dat, mdat;
  logic [31:0] mcnt;

  initial begin
    int g3 [6];
    int g4 [3];
    logic [3:0] eg;
    int gi;
    logic [7:0] d;
    logic [3:0] sh;
    g3 = '{3, 0, 1, 3, 0, 1};
    g4 = '{2, 3, 0};

    reset_n = 1'b0;
    cke     = 1'b1;
    s_valid = 4'h0;
    s_mask  = 4'hF;
    s_shift = '0;
    s_data  = '0;
    s_tag   = '0;
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", issue_count, 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_id", 32'(m_id), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // All four requesters valid: rotation 0,1,2,3,0,1
    set_ramp();
    s_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rot_ready", 32'(s_ready), 32'(4'b0001 << (c % 4)));
      tick();
      chk("rot_busy", 32'(busy), 32'd1);
      if (c >= 1) begin
        chk("rot_m_valid", 32'(m_valid), 32'd1);
        chk("rot_m_id", 32'(m_id), 32'((c - 1) % 4));
        chk("rot_m_tag", 32'(m_tag), 32'((c - 1) % 4));
        chk("rot_m_data", 32'(m_data), 32'(8'h01 << ((c - 1) % 4)));
      end else begin
        chk("rot_first_latency", 32'(m_valid), 32'd0);
      end
    end
    s_valid = 4'h0;
    tick();
    chk("rot_last_id", 32'(m_id), 32'd1);
    chk("rot_last_data", 32'(m_data), 32'h02);
    tick();
    chk("rot_idle_valid", 32'(m_valid), 32'd0);
    chk("rot_hold_data", 32'(m_data), 32'h02);
    chk("rot_idle_busy", 32'(busy), 32'd0);
    chk("rot_count", issue_count, 32'd6);

    // Single requester 2, oversize shift flushes the data
    s_data[2*8 +: 8]  = 8'hFF;
    s_shift[2*4 +: 4] = 4'd9;
    s_tag[2*4 +: 4]   = 4'd5;
    s_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("one_ready", 32'(s_ready), 32'h4);
      tick();
      if (c >= 1) begin
        chk("one_m_id", 32'(m_id), 32'd2);
        chk("one_m_tag", 32'(m_tag), 32'd5);
        chk("one_m_data", 32'(m_data), 32'd0);
      end
    end
    s_valid = 4'h0;
    tick();
    chk("one_last_valid", 32'(m_valid), 32'd1);
    tick();
    chk("one_count", issue_count, 32'd10);

    // Requester 2 masked: rotation skips it
    set_ramp();
    s_mask  = 4'b1011;
    s_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("mask_ready", 32'(s_ready), 32'(4'b0001 << g3[c]));
      tick();
      chk("mask_count", issue_count, 32'(10 + c + 1));
      if (c >= 1) begin
        chk("mask_m_id", 32'(m_id), 32'(g3[c-1]));
        chk("mask_m_data", 32'(m_data), 32'(8'h01 << g3[c-1]));
      end
    end
    s_valid = 4'h0;
    tick();
    tick();
    chk("mask_idle", 32'(m_valid), 32'd0);

    // Three issues then a five-cycle clock-enable stall
    s_mask  = 4'hF;
    s_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_issue_ready", 32'(s_ready), 32'(4'b0001 << g4[c]));
      tick();
    end
    chk("stall_pre_id", 32'(m_id), 32'd3);
    cke = 1'b0;
    #1;
    chk("stall_ready", 32'(s_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_m_id", 32'(m_id), 32'd3);
      chk("stall_m_data", 32'(m_data), 32'h08);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_count", issue_count, 32'd19);
    end
    cke     = 1'b1;
    s_valid = 4'h0;
    tick();
    chk("resume_m_valid", 32'(m_valid), 32'd1);
    chk("resume_m_id", 32'(m_id), 32'd0);
    chk("resume_m_data", 32'(m_data), 32'h01);
    tick();
    chk("resume_drain_valid", 32'(m_valid), 32'd0);
    chk("resume_drain_busy", 32'(busy), 32'd0);

    // Asynchronous reset with two results in flight
    s_valid = 4'hF;
    #1;
    chk("ar_ready0", 32'(s_ready), 32'h2);
    tick();
    chk("ar_ready1", 32'(s_ready), 32'h4);
    tick();
    chk("ar_pre_valid", 32'(m_valid), 32'd1);
    chk("ar_pre_id", 32'(m_id), 32'd1);
    s_valid = 4'h0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_count", issue_count, 32'd0);
    chk("ar_m_data", 32'(m_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ar_no_stale", 32'(m_valid), 32'd0);
    end
    s_valid = 4'hF;
    #1;
    chk("ar_ptr_restart", 32'(s_ready), 32'h1);
    s_valid = 4'h0;

    // Random phase against a reference model (state is post-reset)
    mptr = 0;
    p0v = 1'b0; p0id = '0; p0tag = '0; p0dat = '0;
    mv  = 1'b0; mid  = '0; mtag  = '0; mdat  = '0;
    mcnt = '0;
    for (int n = 0; n < 2000; n++) begin
      s_valid = 4'($urandom);
      s_mask  = 4'($urandom);
      s_shift = 16'($urandom);
      s_data  = $urandom;
      s_tag   = 16'($urandom);
      cke     = ($urandom_range(0, 4) != 0);
      eg = '0;
      gi = -1;
      if (cke) begin
        for (int k = 0; k < 4; k++) begin
          if (gi < 0 && s_valid[(mptr + k) % 4] && s_mask[(mptr + k) % 4])
            gi = (mptr + k) % 4;
        end
      end
      if (gi >= 0) eg[gi] = 1'b1;
      #1;
      chk("rnd_ready", 32'(s_ready), 32'(eg));
      if (cke) begin
        if (p0v) begin
          mid = p0id; mtag = p0tag; mdat = p0dat;
        end
        mv  = p0v;
        p0v = (gi >= 0);
        if (gi >= 0) begin
          d     = s_data[gi*8 +: 8];
          sh    = s_shift[gi*4 +: 4];
          p0id  = 2'(gi);
          p0tag = s_tag[gi*4 +: 4];
          p0dat = (sh >= 4'd8) ? 8'h00 : 8'(d << sh);
          mptr  = (gi + 1) % 4;
          mcnt  = mcnt + 32'd1;
        end
      end
      tick();
      chk("rnd_m_valid", 32'(m_valid), 32'(mv));
      chk("rnd_m_id", 32'(m_id), 32'(mid));
      chk("rnd_m_tag", 32'(m_tag), 32'(mtag));
      chk("rnd_m_data", 32'(m_data), 32'(mdat));
      chk("rnd_busy", 32'(busy), 32'(p0v | mv));
    end
    chk("rnd_count", issue_count, mcnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
